// File: rtl/if_id_pipe.sv
// IF/ID pipeline register for the 5-stage MIPS pipeline: load-use interlock,
// control-flow flush and saturating stall/flush event counters.
module if_id_pipe #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic [31:0] NOP       = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instruction_if,
    input  logic [31:0]          NextPC_if,
    input  logic                 Z,
    input  logic                 J,
    input  logic                 JR,
    input  logic                 MemRead_ex,
    input  logic [4:0]           Rt_ex,
    input  logic                 Hold,
    output logic                 PC_IFWrite,
    output logic [31:0]          Instruction_id,
    output logic [31:0]          NextPC_id,
    output logic                 Valid_id,
    output logic                 Bubble_id,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount
);

    logic [31:0]          r_instr;
    logic [31:0]          r_npc;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic [5:0]           w_op;
    logic [4:0]           w_rs;
    logic [4:0]           w_rt;
    logic                 w_uses_rt;
    logic                 w_lu_hazard;
    logic                 w_redirect;
    logic                 w_pc_write;
    logic                 w_bubble;

    // Event counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    assign w_op       = r_instr[31:26];
    assign w_rs       = r_instr[25:21];
    assign w_rt       = r_instr[20:16];
    assign w_redirect = Z | J | JR;

    // R-type, beq, bne and sw read rt as a source operand.
    always_comb begin
        w_uses_rt = 1'b0;
        case (w_op)
            6'h00, 6'h04, 6'h05, 6'h2B: w_uses_rt = 1'b1;
            default:                    w_uses_rt = 1'b0;
        endcase
    end

    assign w_lu_hazard = r_valid & MemRead_ex & (Rt_ex != 5'd0) &
                         ((Rt_ex == w_rs) | (w_uses_rt & (Rt_ex == w_rt)));

    // Fetch enable and decode bubble, prioritised Hold > redirect > hazard.
    always_comb begin
        w_pc_write = 1'b1;
        w_bubble   = 1'b0;
        if (Hold) begin
            w_pc_write = 1'b0;
            w_bubble   = 1'b0;
        end else if (w_redirect) begin
            w_pc_write = 1'b1;
            w_bubble   = 1'b0;
        end else if (w_lu_hazard) begin
            w_pc_write = 1'b0;
            w_bubble   = 1'b1;
        end else begin
            w_pc_write = 1'b1;
            w_bubble   = 1'b0;
        end
    end

    // Pipeline register and event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr     <= NOP;
            r_npc       <= 32'h0000_0000;
            r_valid     <= 1'b0;
            r_stall_cnt <= {CNT_WIDTH{1'b0}};
            r_flush_cnt <= {CNT_WIDTH{1'b0}};
        end else if (Hold) begin
            r_instr     <= r_instr;
            r_npc       <= r_npc;
            r_valid     <= r_valid;
        end else if (w_redirect) begin
            // The held instruction is on the wrong path: squash it.
            r_instr     <= NOP;
            r_npc       <= NextPC_if;
            r_valid     <= 1'b0;
            r_flush_cnt <= sat_inc(r_flush_cnt);
        end else if (w_lu_hazard) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end else begin
            r_instr     <= Instruction_if;
            r_npc       <= NextPC_if;
            r_valid     <= 1'b1;
        end
    end

    assign PC_IFWrite     = w_pc_write;
    assign Bubble_id      = w_bubble;
    assign Instruction_id = r_instr;
    assign NextPC_id      = r_npc;
    assign Valid_id       = r_valid;
    assign StallCount     = r_stall_cnt;
    assign FlushCount     = r_flush_cnt;

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: vector table with a scoreboard queue,
// plus reset-in-stall and counter saturation sequences.
module tb_if_id_pipe;

    typedef struct {
        logic [31:0] instr_if;
        logic [31:0] npc_if;
        logic        z, j, jr, mr, hold;
        logic [4:0]  rt_ex;
        logic        exp_pcw, exp_bub;
        logic [31:0] exp_instr, exp_npc;
        logic        exp_valid;
        logic [15:0] exp_stall, exp_flush;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] instr, npc;
        logic        valid;
        logic [15:0] stall, flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_if = 32'h0, npc_if = 32'h0;
    logic        z = 1'b0, j = 1'b0, jr = 1'b0, mr = 1'b0, hold = 1'b0;
    logic [4:0]  rt_ex = 5'd0;
    logic        pcw, bub, valid_id;
    logic [31:0] instr_id, npc_id;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_reset = 1'b1;
    logic [31:0] s_instr = 32'h0;
    logic        s_mr = 1'b0;
    logic [4:0]  s_rt = 5'd0;
    logic        s_pcw, s_bub, s_valid;
    logic [31:0] s_instr_id, s_npc_id;
    logic [3:0]  s_stall, s_flush;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[18];
    exp_t sb[$];

    always #5 clk = ~clk;

    if_id_pipe #(.CNT_WIDTH(16), .NOP(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .Instruction_if(instr_if), .NextPC_if(npc_if),
        .Z(z), .J(j), .JR(jr), .MemRead_ex(mr), .Rt_ex(rt_ex), .Hold(hold),
        .PC_IFWrite(pcw), .Instruction_id(instr_id), .NextPC_id(npc_id),
        .Valid_id(valid_id), .Bubble_id(bub), .StallCount(stall_cnt), .FlushCount(flush_cnt)
    );

    if_id_pipe #(.CNT_WIDTH(4), .NOP(32'h0000_0000)) dut_sat (
        .clk(clk), .reset(s_reset), .Instruction_if(s_instr), .NextPC_if(32'h0000_0040),
        .Z(1'b0), .J(1'b0), .JR(1'b0), .MemRead_ex(s_mr), .Rt_ex(s_rt), .Hold(1'b0),
        .PC_IFWrite(s_pcw), .Instruction_id(s_instr_id), .NextPC_id(s_npc_id),
        .Valid_id(s_valid), .Bubble_id(s_bub), .StallCount(s_stall), .FlushCount(s_flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ii, input logic [31:0] np,
                                input logic zz, input logic jj, input logic jjr,
                                input logic m, input logic [4:0] r, input logic h,
                                input logic epcw, input logic ebub,
                                input logic [31:0] ei, input logic [31:0] en,
                                input logic ev, input logic [15:0] es, input logic [15:0] ef);
        vec_t v;
        v.instr_if = ii; v.npc_if = np; v.z = zz; v.j = jj; v.jr = jjr;
        v.mr = m; v.rt_ex = r; v.hold = h; v.exp_pcw = epcw; v.exp_bub = ebub;
        v.exp_instr = ei; v.exp_npc = en; v.exp_valid = ev; v.exp_stall = es; v.exp_flush = ef;
        return v;
    endfunction

    // Drive one vector, check same-cycle outputs, then check the registered result after the edge.
    task automatic step(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        instr_if = v.instr_if; npc_if = v.npc_if; z = v.z; j = v.j; jr = v.jr;
        mr = v.mr; rt_ex = v.rt_ex; hold = v.hold;
        #1;
        chk($sformatf("vec%0d PC_IFWrite", idx), {31'd0, pcw}, {31'd0, v.exp_pcw});
        chk($sformatf("vec%0d Bubble_id", idx), {31'd0, bub}, {31'd0, v.exp_bub});
        e.idx = idx; e.instr = v.exp_instr; e.npc = v.exp_npc; e.valid = v.exp_valid;
        e.stall = v.exp_stall; e.flush = v.exp_flush;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk($sformatf("vec%0d Instruction_id", got.idx), instr_id, got.instr);
        chk($sformatf("vec%0d NextPC_id", got.idx), npc_id, got.npc);
        chk($sformatf("vec%0d Valid_id", got.idx), {31'd0, valid_id}, {31'd0, got.valid});
        chk($sformatf("vec%0d StallCount", got.idx), {16'd0, stall_cnt}, {16'd0, got.stall});
        chk($sformatf("vec%0d FlushCount", got.idx), {16'd0, flush_cnt}, {16'd0, got.flush});
    endtask

    initial begin
        //              instr_if      npc    Z     J     JR    MR    Rt     Hold  pcw   bub   instr_id      npc_id valid stall flush
        vecs[0]  = mk(32'h8C080004, 32'h04, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h8C080004, 32'h04, 1'b1, 16'd0, 16'd0);
        vecs[1]  = mk(32'h010A4820, 32'h08, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h010A4820, 32'h08, 1'b1, 16'd0, 16'd0);
        vecs[2]  = mk(32'h8D490000, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b1, 32'h010A4820, 32'h08, 1'b1, 16'd1, 16'd0);
        vecs[3]  = mk(32'h8D490000, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8,  1'b0, 1'b1, 1'b0, 32'h8D490000, 32'h0C, 1'b1, 16'd1, 16'd0);
        vecs[4]  = mk(32'h8C090000, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 1'b0, 32'h8C090000, 32'h10, 1'b1, 16'd1, 16'd0);
        vecs[5]  = mk(32'hAD2A0004, 32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 32'hAD2A0004, 32'h14, 1'b1, 16'd1, 16'd0);
        vecs[6]  = mk(32'h012A4020, 32'h18, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1, 32'hAD2A0004, 32'h14, 1'b1, 16'd2, 16'd0);
        vecs[7]  = mk(32'h012A4020, 32'h18, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h00000000, 32'h18, 1'b0, 16'd2, 16'd1);
        vecs[8]  = mk(32'h010A4820, 32'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h010A4820, 32'h1C, 1'b1, 16'd2, 16'd1);
        vecs[9]  = mk(32'h11111111, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b0, 32'h00000000, 32'h20, 1'b0, 16'd2, 16'd2);
        vecs[10] = mk(32'h010A4820, 32'h24, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h010A4820, 32'h24, 1'b1, 16'd2, 16'd2);
        vecs[11] = mk(32'hDEADBEEF, 32'h99, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 32'h010A4820, 32'h24, 1'b1, 16'd2, 16'd2);
        vecs[12] = mk(32'hDEADBEEF, 32'h99, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 32'h010A4820, 32'h24, 1'b1, 16'd2, 16'd2);
        vecs[13] = mk(32'hDEADBEEF, 32'h99, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 32'h010A4820, 32'h24, 1'b1, 16'd2, 16'd2);
        vecs[14] = mk(32'hDEADBEEF, 32'h28, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  1'b0, 1'b1, 1'b0, 32'h00000000, 32'h28, 1'b0, 16'd2, 16'd3);
        vecs[15] = mk(32'h1109FFFF, 32'h2C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h1109FFFF, 32'h2C, 1'b1, 16'd2, 16'd3);
        vecs[16] = mk(32'h00000000, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 32'h1109FFFF, 32'h2C, 1'b1, 16'd3, 16'd3);
        vecs[17] = mk(32'h00000000, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h00000000, 32'h30, 1'b1, 16'd3, 16'd3);

        // Asynchronous reset asserted mid-cycle; values must clear without a clock edge.
        #2;
        reset = 1'b0;
        s_reset = 1'b0;
        #1;
        chk("reset Instruction_id", instr_id, 32'h0);
        chk("reset NextPC_id", npc_id, 32'h0);
        chk("reset Valid_id", {31'd0, valid_id}, 32'd0);
        chk("reset StallCount", {16'd0, stall_cnt}, 32'd0);
        chk("reset FlushCount", {16'd0, flush_cnt}, 32'd0);
        chk("reset PC_IFWrite", {31'd0, pcw}, 32'd1);
        chk("reset Bubble_id", {31'd0, bub}, 32'd0);
        #9;
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(i, vecs[i]);
        end

        // Reset asserted in the middle of a load-use stall.
        instr_if = 32'h010A4820; npc_if = 32'h34; mr = 1'b0; rt_ex = 5'd0;
        @(posedge clk);
        #1;
        mr = 1'b1; rt_ex = 5'd8;
        #1;
        chk("stall-before-reset PC_IFWrite", {31'd0, pcw}, 32'd0);
        chk("stall-before-reset Bubble_id", {31'd0, bub}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("reset-in-stall Instruction_id", instr_id, 32'h0);
        chk("reset-in-stall Valid_id", {31'd0, valid_id}, 32'd0);
        chk("reset-in-stall StallCount", {16'd0, stall_cnt}, 32'd0);
        chk("reset-in-stall FlushCount", {16'd0, flush_cnt}, 32'd0);
        chk("reset-in-stall PC_IFWrite", {31'd0, pcw}, 32'd1);
        chk("reset-in-stall Bubble_id", {31'd0, bub}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1; mr = 1'b0; rt_ex = 5'd0; instr_if = 32'h8C080004; npc_if = 32'h04;
        @(posedge clk);
        #1;
        chk("post-reset Instruction_id", instr_id, 32'h8C080004);
        chk("post-reset Valid_id", {31'd0, valid_id}, 32'd1);
        chk("post-reset StallCount", {16'd0, stall_cnt}, 32'd0);

        // Saturation of a 4-bit stall counter under a persistent hazard.
        s_reset = 1'b1; s_instr = 32'h010A4820; s_mr = 1'b0; s_rt = 5'd0;
        @(posedge clk);
        #1;
        s_mr = 1'b1; s_rt = 5'd8;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat cycle%0d StallCount", k), {28'd0, s_stall},
                (k < 15) ? k : 32'd15);
        end
        chk("sat PC_IFWrite", {31'd0, s_pcw}, 32'd0);
        chk("sat Bubble_id", {31'd0, s_bub}, 32'd1);
        chk("sat Instruction_id", s_instr_id, 32'h010A4820);
        chk("sat FlushCount", {28'd0, s_flush}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
- IF/ID pipeline register with load-use hazard interlock and control-flow flush for the 5-stage MIPS pipeline.
- Captures `Instruction_if` / `NextPC_if` from the fetch stage and presents them to decode.
- Drives `PC_IFWrite` back to fetch to freeze the PC on a load-use hazard.
- Squashes the fetched instruction when a branch, jump or jump-register redirect is taken.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- `CNT_WIDTH`, 16, width of each saturating event counter.
- `NOP`, 32'h00000000, instruction word injected on flush and reset (sll $0,$0,0).

Ports:
- `clk`, input, 1, rising-edge clock.
- `reset`, input, 1, asynchronous active-low reset.
- `Instruction_if`, input, 32, fetched instruction.
- `NextPC_if`, input, 32, PC+4 of the fetched instruction.
- `Z`, input, 1, taken branch redirect, same encoding as the fetch PC mux select.
- `J`, input, 1, jump redirect.
- `JR`, input, 1, jump-register redirect.
- `MemRead_ex`, input, 1, instruction currently in EX is a load.
- `Rt_ex`, input, 5, destination register of the instruction in EX.
- `Hold`, input, 1, global freeze (debug/memory wait).
- `PC_IFWrite`, output, 1, PC write enable to fetch.
- `Instruction_id`, output, 32, registered instruction to decode.
- `NextPC_id`, output, 32, registered PC+4 to decode.
- `Valid_id`, output, 1, `Instruction_id` is a real instruction (0 = bubble/flushed).
- `Bubble_id`, output, 1, decode must zero its control outputs into ID/EX this cycle.
- `StallCount`, output, CNT_WIDTH, number of load-use stall cycles.
- `FlushCount`, output, CNT_WIDTH, number of flush events.

Behaviour:

Reset (reset=0, asynchronous):
- `Instruction_id`=NOP, `NextPC_id`=0, `Valid_id`=0.
- Both counters =0.
- Combinational outputs follow from `Valid_id`=0: `Bubble_id`=0, `PC_IFWrite`=1 (unless `Hold`).
- Reset asserted mid-stall clears everything immediately; no stall survives reset.

Combinational decode of the held instruction:
- op=`Instruction_id[31:26]`, rs=`[25:21]`, rt=`[20:16]`.
- `uses_rt` = op in {0x00, 0x04, 0x05, 0x2B}.
- `lu_hazard` = `Valid_id` & `MemRead_ex` & (`Rt_ex`≠0) & ((`Rt_ex`==rs) | (`uses_rt` & `Rt_ex`==rt)).
- `redirect` = `Z` | `J` | `JR`.

Priority per cycle (highest first): `Hold`, `redirect`, `lu_hazard`, normal.
- Hold:
  - `PC_IFWrite`=0, `Bubble_id`=0.
  - All registers keep their value; counters unchanged.
- Redirect:
  - `PC_IFWrite`=1, `Bubble_id`=0.
  - Next edge: `Instruction_id`←NOP, `NextPC_id`←`NextPC_if`, `Valid_id`←0.
  - `FlushCount`+1, saturating at all-ones.
  - Redirect overrides a simultaneous `lu_hazard`. The redirecting instruction is already past ID, so the held instruction is on the wrong path.
- Load-use stall:
  - `PC_IFWrite`=0, `Bubble_id`=1.
  - IF/ID registers hold.
  - `StallCount`+1, saturating.
- Normal:
  - `PC_IFWrite`=1, `Bubble_id`=0.
  - Next edge: `Instruction_id`←`Instruction_if`, `NextPC_id`←`NextPC_if`, `Valid_id`←1.

Timing rules:
- Latency is exactly one cycle from IF to ID.
- A load-use stall lasts exactly one cycle. The bubble leaves the load in MEM on the following cycle, so `MemRead_ex` deasserts and the hazard clears without any internal state.
- Outputs `PC_IFWrite` and `Bubble_id` are combinational from registered state plus same-cycle inputs. There is no combinational path from `Instruction_if` to any output.
- Counters wrap never: at all-ones they stay at all-ones.

Test Plan:
1. Reset: assert reset low mid-cycle, then release → immediately `Instruction_id`=0, `Valid_id`=0, counters 0, `PC_IFWrite`=1. First edge after release with `Instruction_if`=32'h8C080004 → `Instruction_id`=32'h8C080004, `Valid_id`=1.
2. Load-use on rs: `Instruction_id`=add $9,$8,$10 (32'h010A4820), `MemRead_ex`=1, `Rt_ex`=8 → `PC_IFWrite`=0, `Bubble_id`=1, `Instruction_id` unchanged next edge, `StallCount`=1. Drop `MemRead_ex` → fetch resumes next edge.
3. Rt-only check: `Instruction_id`=lw $9,0($10) (rt=9 not a source), `Rt_ex`=9, `MemRead_ex`=1 → no stall. The same case with `Rt_ex`=0 and rs=0 → no stall.
4. Flush: `J`=1 with `Instruction_if`=32'h012A4020 → next edge `Instruction_id`=0, `Valid_id`=0, `FlushCount`=1. Assert `Z`=1 concurrently with a load-use hazard → flush taken, `PC_IFWrite`=1, `StallCount` unchanged.
5. Hold: `Hold`=1 for 3 cycles while a hazard and `JR`=1 are present → `PC_IFWrite`=0, `Bubble_id`=0, registers and counters frozen.
6. Saturation: force 2^CNT_WIDTH+2 stall cycles (`CNT_WIDTH`=4 instance) → `StallCount`=4'hF and stays there.
